clk_div_monitor: RTL and testbench
==================================

# clk_div_monitor

Checks a divided clock produced elsewhere in the design against its expected ratio. `clk_in` is treated as asynchronous data and sampled in the `sys_clk` domain. The block measures the rising-edge-to-rising-edge period in `sys_clk` cycles and declares lock after a run of correct periods. It flags mis-sized periods and a stopped clock, so that bring-up and self-test logic can confirm the divider output.

## Interface
- `EXP_PERIOD`, 5: expected `clk_in` period in `sys_clk` cycles; must be ≥ 3.
- `CNT_W`, 8: counter/output width; must hold `2*EXP_PERIOD`.
- `LOCK_CNT`, 4: consecutive good periods required to assert `locked`; must be ≥ 1.
- `sys_clk  input  1  system clock; all logic on its rising edge.`
- `sys_rst_n  input  1  asynchronous active-low reset.`
- `clk_in  input  1  divided clock under test, asynchronous to sys_clk.`
- `period_out  output  CNT_W  last captured period; held between captures.`
- `high_out  output  CNT_W  high-sample count of the last captured period; 0 when the duty check is compiled out.`
- `period_valid  output  1  one-cycle pulse on each capture.`
- `locked  output  1  level; high in LOCKED state.`
- `err  output  1  one-cycle pulse on each bad period or timeout.`

## Operation
- Synchronizer: `clk_in` → `s1` → `s2`; `s3` is the previous `s2`; `rise = s2 & ~s3`.
- Period counter `per_cnt`:
  - loads 1 on `rise`;
  - otherwise increments, saturating at `2*EXP_PERIOD`.
- High counter (`DUTY_CHECK_EN` only): loads 1 on `rise`; otherwise adds `s2`.
- States: IDLE, MEASURE, LOCKED.
  - IDLE: no timeout and no capture. On `rise`, go to MEASURE and clear `good_cnt`. This first edge is the reference only.
  - MEASURE/LOCKED on `rise`:
    - Capture `period_out <= per_cnt` and pulse `period_valid`.
    - Good iff `per_cnt == EXP_PERIOD` (and the duty check passes when enabled).
    - Good in MEASURE: `good_cnt++`; on reaching `LOCK_CNT`, go to LOCKED.
    - Bad in MEASURE: `good_cnt <= 0` and pulse `err`.
    - Bad in LOCKED: go to MEASURE, `good_cnt <= 0`, `locked` falls, pulse `err`.
  - MEASURE/LOCKED with no `rise` and `per_cnt == 2*EXP_PERIOD` (timeout): go to IDLE, pulse `err`, `locked <= 0`, no capture.
- Simultaneous `rise` and timeout: `rise` wins. Capture `2*EXP_PERIOD` as a bad period; do not enter IDLE.
- Reset: all outputs, counters and sync flops go to 0; state goes to IDLE.
  - Applies asynchronously at any time, including mid-lock.
  - After release, operation restarts from IDLE.

## Timing
- The first `sys_clk` edge that samples `clk_in` high is edge 0. `rise` becomes combinationally true after edge 1. All outputs are registered and update at edge 2.
- Capture to `period_valid`/`err`/`locked` change: same registered edge; pulses last one cycle.
- Ideal clk/5: a capture every 5 cycles. The first capture occurs at the second rise. `locked` rises with the `LOCK_CNT`-th good capture, which is the (`LOCK_CNT`+1)-th rise.
- Timeout fires exactly `2*EXP_PERIOD` cycles after the last `rise` (at the cycle in which `per_cnt` holds `2*EXP_PERIOD`).

## Configuration
- `CLK_MON_DUTY_CHECK_EN` defined:
  - The high counter is built, and `high_out` is loaded on each capture.
  - A period is good only if, in addition, high count ∈ {`EXP_PERIOD/2`, `(EXP_PERIOD+1)/2`} (integer division). This accepts 2 or 3 for 5.
- Undefined:
  - No high counter; `high_out` is tied to 0.
  - Goodness depends on the period only.

## Structure
- Package `clk_mon_pkg`: state enum (IDLE=2'd0, MEASURE=2'd1, LOCKED=2'd2) and the duty-bound helper constants.
- Sub-module `clk_mon_sync`: 2-flop synchronizer plus edge register. Outputs `s2` and `rise`; reset to 0.

## Test plan
- Reset held, `clk_in` toggling → all outputs 0. Release with `clk_in`=0 for 50 cycles → no `err` (IDLE has no timeout).
- Ideal clk/5 → first `period_valid` with `period_out`=5 at the 2nd rise; `locked`=1 at the 5th rise; `err` never pulses.
- While locked, stretch one period to 7 → `period_out`=7, `err` pulse, `locked`=0; `locked` returns after 4 further good periods.
- While locked, hold `clk_in` high → `err` pulse exactly 10 cycles after the last rise, `locked`=0, no `period_valid`. Restore clk/5 → relocks after 5 rises.
- Assert `sys_rst_n` low mid-lock between clock edges → `locked`, `period_out` and `high_out` go to 0 immediately.
- Period 5 with 1 high cycle:
  - with `CLK_MON_DUTY_CHECK_EN` → `high_out`=1, `err` on every capture, never locks;
  - without the macro → locks normally, `high_out`=0.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the divided-clock monitor: state encoding and
// the duty-cycle acceptance bounds derived from the expected period.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } mon_state_e;

    // Lower bound of the accepted high-sample count for a given period.
    function automatic int duty_lo(input int exp_period);
        return exp_period / 2;
    endfunction

    // Upper bound of the accepted high-sample count; equals duty_lo for even periods.
    function automatic int duty_hi(input int exp_period);
        return (exp_period + 1) / 2;
    endfunction

endpackage

// File: rtl/clk_mon_sync.sv
// Two-flop synchronizer for the monitored clock plus a one-cycle history flop
// used to detect rising edges in the sys_clk domain.
module clk_mon_sync (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clk_in,
    output logic s2,
    output logic rise
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // Synchronizer chain and edge-history register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= clk_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign s2   = s2_r;
    assign rise = s2_r & ~s3_r;

endmodule

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: measures clk_in rise-to-rise periods in sys_clk cycles,
// locks after LOCK_CNT good periods, flags bad periods and a stopped clock.
// Optional duty-cycle check is built when CLK_MON_DUTY_CHECK_EN is defined.
module clk_div_monitor
    import clk_mon_pkg::*;
#(
    parameter int EXP_PERIOD = 5,
    parameter int CNT_W      = 8,
    parameter int LOCK_CNT   = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             period_valid,
    output logic             locked,
    output logic             err
);

    localparam int               GOOD_W   = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] PER_SAT  = CNT_W'(2 * EXP_PERIOD);
    localparam logic [CNT_W-1:0] EXP_CNT  = CNT_W'(EXP_PERIOD);
    localparam logic [GOOD_W-1:0] LOCK_TGT = GOOD_W'(LOCK_CNT);

    logic              s2_s;
    logic              rise_s;
    logic              duty_ok_s;
    logic              good_s;
    logic [CNT_W-1:0]  per_cnt_r;
    logic [GOOD_W-1:0] good_cnt_r;
    mon_state_e        state_r;

    clk_mon_sync u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clk_in    (clk_in),
        .s2        (s2_s),
        .rise      (rise_s)
    );

    // Period counter: restarts at 1 on each rise and saturates at the timeout value.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            per_cnt_r <= {CNT_W{1'b0}};
        end else if (rise_s) begin
            per_cnt_r <= CNT_W'(1);
        end else if (per_cnt_r != PER_SAT) begin
            per_cnt_r <= per_cnt_r + CNT_W'(1);
        end else begin
            per_cnt_r <= per_cnt_r;
        end
    end

`ifdef CLK_MON_DUTY_CHECK_EN
    localparam logic [CNT_W-1:0] DUTY_LO = CNT_W'(duty_lo(EXP_PERIOD));
    localparam logic [CNT_W-1:0] DUTY_HI = CNT_W'(duty_hi(EXP_PERIOD));

    logic [CNT_W-1:0] high_cnt_r;
    logic [CNT_W-1:0] high_out_r;

    // High-sample counter; the rise cycle itself is the first high sample.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            high_cnt_r <= {CNT_W{1'b0}};
        end else if (rise_s) begin
            high_cnt_r <= CNT_W'(1);
        end else if (s2_s && (high_cnt_r != PER_SAT)) begin
            high_cnt_r <= high_cnt_r + CNT_W'(1);
        end else begin
            high_cnt_r <= high_cnt_r;
        end
    end

    // High count is published alongside period_out on every capture.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            high_out_r <= {CNT_W{1'b0}};
        end else if (rise_s && (state_r != IDLE)) begin
            high_out_r <= high_cnt_r;
        end else begin
            high_out_r <= high_out_r;
        end
    end

    assign duty_ok_s = (high_cnt_r == DUTY_LO) || (high_cnt_r == DUTY_HI);
    assign high_out  = high_out_r;
`else
    logic unused_s2_s;

    assign unused_s2_s = s2_s;
    assign duty_ok_s   = 1'b1;
    assign high_out    = {CNT_W{1'b0}};
`endif

    assign good_s = (per_cnt_r == EXP_CNT) && duty_ok_s;

    // Lock FSM with registered status outputs; a rise coinciding with timeout is a capture.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r      <= IDLE;
            good_cnt_r   <= {GOOD_W{1'b0}};
            period_out   <= {CNT_W{1'b0}};
            period_valid <= 1'b0;
            locked       <= 1'b0;
            err          <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            err          <= 1'b0;
            case (state_r)
                IDLE: begin
                    locked <= 1'b0;
                    if (rise_s) begin
                        state_r    <= MEASURE;
                        good_cnt_r <= {GOOD_W{1'b0}};
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MEASURE, LOCKED: begin
                    if (rise_s) begin
                        period_out   <= per_cnt_r;
                        period_valid <= 1'b1;
                        if (!good_s) begin
                            state_r    <= MEASURE;
                            good_cnt_r <= {GOOD_W{1'b0}};
                            locked     <= 1'b0;
                            err        <= 1'b1;
                        end else if (state_r == LOCKED) begin
                            locked <= 1'b1;
                        end else if ((good_cnt_r + GOOD_W'(1)) == LOCK_TGT) begin
                            state_r    <= LOCKED;
                            good_cnt_r <= LOCK_TGT;
                            locked     <= 1'b1;
                        end else begin
                            good_cnt_r <= good_cnt_r + GOOD_W'(1);
                        end
                    end else if (per_cnt_r == PER_SAT) begin
                        state_r    <= IDLE;
                        good_cnt_r <= {GOOD_W{1'b0}};
                        locked     <= 1'b0;
                        err        <= 1'b1;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    good_cnt_r <= {GOOD_W{1'b0}};
                    locked     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomized self-checking bench for clk_div_monitor; expectations come from a
// sample-history model that measures periods directly from the driven waveform.
module tb_clk_div_monitor;

    localparam int EXP_PERIOD = 5;
    localparam int CNT_W      = 8;
    localparam int LOCK_CNT   = 4;
    localparam int SAT        = 2 * EXP_PERIOD;

    logic             sys_clk;
    logic             sys_rst_n;
    logic             clk_in;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             period_valid;
    logic             locked;
    logic             err;

    int checks = 0;
    int passed = 0;

    bit hist[$];
    bit stim_q[$];
    int last_rise;
    bit tracking;
    int good_run;
    bit e_pv, e_err, e_lk;
    int e_po, e_ho;

    clk_div_monitor #(
        .EXP_PERIOD (EXP_PERIOD),
        .CNT_W      (CNT_W),
        .LOCK_CNT   (LOCK_CNT)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .clk_in       (clk_in),
        .period_out   (period_out),
        .high_out     (high_out),
        .period_valid (period_valid),
        .locked       (locked),
        .err          (err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic void model_reset();
        hist.delete();
        tracking  = 1'b0;
        good_run  = 0;
        last_rise = -1000;
        e_pv = 1'b0; e_err = 1'b0; e_lk = 1'b0; e_po = 0; e_ho = 0;
    endfunction

    // One sys_clk edge: a level rise seen two samples ago is acted on now.
    function automatic void model_edge(input bit lvl);
        int t, elapsed, h;
        bit rise, ok;
        hist.push_back(lvl);
        t = hist.size() - 1;
        rise = (t >= 2) && hist[t-2] && !((t >= 3) ? hist[t-3] : 1'b0);
        elapsed = t - last_rise;
        e_pv = 1'b0;
        e_err = 1'b0;
        if (rise) begin
            if (tracking) begin
                e_pv = 1'b1;
                e_po = (elapsed > SAT) ? SAT : elapsed;
                h = 0;
                for (int i = last_rise - 2; i <= t - 3; i++) h += int'(hist[i]);
                ok = (e_po == EXP_PERIOD);
`ifdef CLK_MON_DUTY_CHECK_EN
                e_ho = h;
                ok = ok && ((h == EXP_PERIOD / 2) || (h == (EXP_PERIOD + 1) / 2));
`endif
                if (ok) good_run++;
                else begin good_run = 0; e_err = 1'b1; end
            end else begin
                tracking = 1'b1;
                good_run = 0;
            end
            last_rise = t;
        end else if (tracking && elapsed >= SAT) begin
            tracking = 1'b0;
            good_run = 0;
            e_err = 1'b1;
        end
        e_lk = tracking && (good_run >= LOCK_CNT);
    endfunction

    function automatic void add_wave(input int per, input int hi, input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < per; i++) stim_q.push_back(i < hi);
    endfunction

    function automatic string obs_str();
        return $sformatf("got pv=%b po=%0d ho=%0d lk=%b err=%b, expected pv=%b po=%0d ho=%0d lk=%b err=%b",
                         period_valid, period_out, high_out, locked, err, e_pv, e_po, e_ho, e_lk, e_err);
    endfunction

    task automatic test_reset();
        sys_rst_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            clk_in = 1'(($urandom() >> 3) & 1);
            @(negedge sys_clk);
            checks++;
            if ({period_valid, period_out, high_out, locked, err} !== {(3 + 2*CNT_W){1'b0}})
                $display("FAIL reset_hold cyc=%0d got pv=%b po=%0d ho=%0d lk=%b err=%b, expected all 0",
                         i, period_valid, period_out, high_out, locked, err);
            else passed++;
        end
        clk_in = 1'b0;
        sys_rst_n = 1'b1;
        model_reset();
        stim_q.delete();
        for (int i = 0; i < 50; i++) stim_q.push_back(1'b0);
        foreach (stim_q[i]) begin
            clk_in = stim_q[i];
            @(posedge sys_clk); model_edge(clk_in);
            @(negedge sys_clk);
            checks++;
            if ({period_valid, period_out, high_out, locked, err} !== {e_pv, e_po[CNT_W-1:0], e_ho[CNT_W-1:0], e_lk, e_err})
                $display("FAIL idle_no_timeout cyc=%0d %s", i, obs_str());
            else passed++;
        end
    endtask

    task automatic test_ideal();
        int pv_cnt = 0, err_cnt = 0;
        bit seen_lock = 1'b0;
        stim_q.delete();
        for (int k = 0; k < 10; k++) add_wave(5, int'($urandom_range(2, 3)), 1);
        foreach (stim_q[i]) begin
            clk_in = stim_q[i];
            @(posedge sys_clk); model_edge(clk_in);
            @(negedge sys_clk);
            checks++;
            if ({period_valid, period_out, high_out, locked, err} !== {e_pv, e_po[CNT_W-1:0], e_ho[CNT_W-1:0], e_lk, e_err})
                $display("FAIL ideal cyc=%0d %s", i, obs_str());
            else passed++;
            if (!seen_lock) begin
                if (period_valid) pv_cnt++;
                if (locked) seen_lock = 1'b1;
            end
            if (err) err_cnt++;
        end
        checks++;
        if (!seen_lock || pv_cnt != LOCK_CNT || err_cnt != 0)
            $display("FAIL ideal_lock_point got lock=%b captures_to_lock=%0d errs=%0d, expected lock=1 captures=%0d errs=0",
                     seen_lock, pv_cnt, err_cnt, LOCK_CNT);
        else passed++;
    endtask

    task automatic test_stretch();
        int err_cnt = 0;
        bit saw7 = 1'b0;
        stim_q.delete();
        add_wave(7, 2, 1);
        add_wave(5, 2, 7);
        foreach (stim_q[i]) begin
            clk_in = stim_q[i];
            @(posedge sys_clk); model_edge(clk_in);
            @(negedge sys_clk);
            checks++;
            if ({period_valid, period_out, high_out, locked, err} !== {e_pv, e_po[CNT_W-1:0], e_ho[CNT_W-1:0], e_lk, e_err})
                $display("FAIL stretch cyc=%0d %s", i, obs_str());
            else passed++;
            if (err) err_cnt++;
            if (period_valid && period_out == CNT_W'(7) && err && !locked) saw7 = 1'b1;
        end
        checks++;
        if (!saw7 || err_cnt != 1 || locked !== 1'b1)
            $display("FAIL stretch_summary got saw7=%b errs=%0d locked=%b, expected saw7=1 errs=1 locked=1",
                     saw7, err_cnt, locked);
        else passed++;
    endtask

    task automatic test_timeout();
        int last_pv = -1, err_cyc = -1;
        stim_q.delete();
        for (int i = 0; i < 20; i++) stim_q.push_back(1'b1);
        for (int i = 0; i < 3; i++) stim_q.push_back(1'b0);
        add_wave(5, 3, 8);
        foreach (stim_q[i]) begin
            clk_in = stim_q[i];
            @(posedge sys_clk); model_edge(clk_in);
            @(negedge sys_clk);
            checks++;
            if ({period_valid, period_out, high_out, locked, err} !== {e_pv, e_po[CNT_W-1:0], e_ho[CNT_W-1:0], e_lk, e_err})
                $display("FAIL timeout cyc=%0d %s", i, obs_str());
            else passed++;
            if (err_cyc < 0) begin
                if (period_valid) last_pv = i;
                if (err) err_cyc = i;
            end
        end
        checks++;
        if (err_cyc < 0 || last_pv < 0 || (err_cyc - last_pv) != SAT || locked !== 1'b1)
            $display("FAIL timeout_distance got %0d cycles (err@%0d pv@%0d) relocked=%b, expected %0d cycles relocked=1",
                     err_cyc - last_pv, err_cyc, last_pv, locked, SAT);
        else passed++;
    endtask

    task automatic test_boundary();
        bit saw_sat = 1'b0;
        stim_q.delete();
        add_wave(SAT, 3, 1);
        add_wave(5, 2, 7);
        foreach (stim_q[i]) begin
            clk_in = stim_q[i];
            @(posedge sys_clk); model_edge(clk_in);
            @(negedge sys_clk);
            checks++;
            if ({period_valid, period_out, high_out, locked, err} !== {e_pv, e_po[CNT_W-1:0], e_ho[CNT_W-1:0], e_lk, e_err})
                $display("FAIL rise_vs_timeout cyc=%0d %s", i, obs_str());
            else passed++;
            if (period_valid && period_out == CNT_W'(SAT) && err) saw_sat = 1'b1;
        end
        checks++;
        if (!saw_sat)
            $display("FAIL rise_vs_timeout_capture got no capture of %0d with err, expected one", SAT);
        else passed++;
    endtask

    task automatic test_duty1();
        int pv_cnt = 0;
        bit late_lock = 1'b0, late_noerr = 1'b0;
        stim_q.delete();
        add_wave(5, 1, 10);
        foreach (stim_q[i]) begin
            clk_in = stim_q[i];
            @(posedge sys_clk); model_edge(clk_in);
            @(negedge sys_clk);
            checks++;
            if ({period_valid, period_out, high_out, locked, err} !== {e_pv, e_po[CNT_W-1:0], e_ho[CNT_W-1:0], e_lk, e_err})
                $display("FAIL duty1 cyc=%0d %s", i, obs_str());
            else passed++;
            if (period_valid) pv_cnt++;
            if (pv_cnt >= 2 && locked) late_lock = 1'b1;
            if (pv_cnt >= 2 && period_valid && (!err || high_out != CNT_W'(1))) late_noerr = 1'b1;
        end
        checks++;
`ifdef CLK_MON_DUTY_CHECK_EN
        if (late_lock || late_noerr || pv_cnt < 8)
            $display("FAIL duty1_reject got late_lock=%b missed_err=%b captures=%0d, expected 0 0 >=8",
                     late_lock, late_noerr, pv_cnt);
        else passed++;
`else
        if (locked !== 1'b1 || high_out !== {CNT_W{1'b0}})
            $display("FAIL duty1_ignored got locked=%b high_out=%0d, expected locked=1 high_out=0", locked, high_out);
        else passed++;
`endif
    endtask

    task automatic test_random();
        int per;
        stim_q.delete();
        for (int w = 0; w < 60; w++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int i = 0; i < int'($urandom_range(9, 14)); i++) stim_q.push_back(1'b1);
                stim_q.push_back(1'b0);
                stim_q.push_back(1'b0);
            end else begin
                per = (($urandom_range(0, 1) == 0)) ? 5 : int'($urandom_range(2, 12));
                add_wave(per, int'($urandom_range(1, per - 1)), 1);
            end
        end
        foreach (stim_q[i]) begin
            clk_in = stim_q[i];
            @(posedge sys_clk); model_edge(clk_in);
            @(negedge sys_clk);
            checks++;
            if ({period_valid, period_out, high_out, locked, err} !== {e_pv, e_po[CNT_W-1:0], e_ho[CNT_W-1:0], e_lk, e_err})
                $display("FAIL random cyc=%0d %s", i, obs_str());
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        stim_q.delete();
        add_wave(5, 2, 8);
        foreach (stim_q[i]) begin
            clk_in = stim_q[i];
            @(posedge sys_clk); model_edge(clk_in);
            @(negedge sys_clk);
            checks++;
            if ({period_valid, period_out, high_out, locked, err} !== {e_pv, e_po[CNT_W-1:0], e_ho[CNT_W-1:0], e_lk, e_err})
                $display("FAIL pre_async_reset cyc=%0d %s", i, obs_str());
            else passed++;
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({period_valid, period_out, high_out, locked, err} !== {(3 + 2*CNT_W){1'b0}})
            $display("FAIL async_reset got pv=%b po=%0d ho=%0d lk=%b err=%b, expected all 0",
                     period_valid, period_out, high_out, locked, err);
        else passed++;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        model_reset();
        stim_q.delete();
        add_wave(5, 3, 8);
        foreach (stim_q[i]) begin
            clk_in = stim_q[i];
            @(posedge sys_clk); model_edge(clk_in);
            @(negedge sys_clk);
            checks++;
            if ({period_valid, period_out, high_out, locked, err} !== {e_pv, e_po[CNT_W-1:0], e_ho[CNT_W-1:0], e_lk, e_err})
                $display("FAIL post_async_reset cyc=%0d %s", i, obs_str());
            else passed++;
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        clk_in    = 1'b0;
        model_reset();
        @(negedge sys_clk);
        test_reset();
        test_ideal();
        test_stretch();
        test_timeout();
        test_boundary();
        test_duty1();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
